// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose: fetch stage between the per-core instruction cache port and the
// decode stage. Holds the PC and a small circular instruction queue, offers a
// valid/ready handshake toward decode, and handles redirects and halt without
// ever changing the cache address while a request is outstanding.
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   iREN, imemaddr       cache read request and word-aligned address
//   ihit, imemload       cache returns the word for imemaddr this cycle
//   redirect, redirect_pc taken branch/jump resolved: flush and refetch
//   halt                 decoded halt: stop fetching permanently
//   instr_valid/ready    handshake toward decode for the queue head
//   instr, instr_pc, instr_npc  queue head word, its PC and PC+4 (0 if empty)
//   halted               fetch permanently stopped (left only by reset)
//
// Optional build macro FETCH_PERF_EN adds saturating counters:
//   fetch_count (32)     queue pushes
//   flush_count (16)     redirects accepted outside HALTED
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          QDEPTH  = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] imemaddr,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_npc,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [15:0] flush_count
`endif
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_FLUSH  = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   flush_addr_q, flush_addr_d;
    logic          halt_pending_q, halt_pending_d;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   qinstr_q [QDEPTH];
    logic [31:0]   qpc_q    [QDEPTH];

    logic          q_full, q_empty;
    logic          req;
    logic          push, pop, q_clear;
    logic [31:0]   redirect_pc_al;

    // Low two bits of the redirect target are ignored: fetch is word aligned.
    assign redirect_pc_al = redirect_pc & ~32'h0000_0003;

    assign q_full  = (count_q == CW'(QDEPTH));
    assign q_empty = (count_q == '0);

    // Request intent from state only; iREN itself is additionally gated by
    // nRST so it drops the instant reset is asserted.
    always_comb begin
        req = 1'b0;
        unique case (state_q)
            S_RUN:    req = !q_full;
            S_FLUSH:  req = 1'b1;
            default:  req = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q        <= S_RUN;
            pc_q           <= PC_INIT;
            flush_addr_q   <= PC_INIT;
            halt_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            flush_addr_q   <= flush_addr_d;
            halt_pending_q <= halt_pending_d;
        end
    end

    // Next-state logic. Halt beats redirect; a miss that is outstanding when
    // either arrives must be allowed to complete at the same address, so the
    // unit parks in FLUSH with the old address and throws that word away.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        flush_addr_d   = flush_addr_q;
        halt_pending_d = halt_pending_q;
        q_clear        = 1'b0;
        push           = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (halt) begin
                    q_clear = 1'b1;
                    if (req && !ihit) begin
                        halt_pending_d = 1'b1;
                        flush_addr_d   = pc_q;
                        state_d        = S_FLUSH;
                    end else begin
                        state_d = S_HALTED;
                    end
                end else if (redirect) begin
                    q_clear = 1'b1;
                    pc_d    = redirect_pc_al;
                    if (req && !ihit) begin
                        flush_addr_d = pc_q;
                        state_d      = S_FLUSH;
                    end
                end else if (req && ihit) begin
                    push = 1'b1;
                    pc_d = pc_q + 32'd4;
                end
            end
            S_FLUSH: begin
                if (halt) begin
                    q_clear = 1'b1;
                    if (ihit) begin
                        state_d = S_HALTED;
                    end else begin
                        halt_pending_d = 1'b1;
                    end
                end else begin
                    if (redirect) begin
                        pc_d = redirect_pc_al;
                    end
                    // The returned word belongs to the abandoned path.
                    if (ihit) begin
                        state_d = halt_pending_q ? S_HALTED : S_RUN;
                    end
                end
            end
            default: begin
                state_d = S_HALTED;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        iREN     = nRST && req;
        imemaddr = (state_q == S_FLUSH) ? flush_addr_q : pc_q;
        halted   = (state_q == S_HALTED);
    end

    // Instruction queue: clear has priority over push/pop in the same cycle.
    assign pop = !q_empty && instr_ready && !q_clear;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (q_clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage needs no reset: entries are only visible through count.
    always_ff @(posedge CLK) begin
        if (push) begin
            qinstr_q[wr_ptr_q] <= imemload;
            qpc_q[wr_ptr_q]    <= pc_q;
        end
    end

    assign instr_valid = !q_empty;
    assign instr       = q_empty ? 32'd0 : qinstr_q[rd_ptr_q];
    assign instr_pc    = q_empty ? 32'd0 : qpc_q[rd_ptr_q];
    assign instr_npc   = q_empty ? 32'd0 : qpc_q[rd_ptr_q] + 32'd4;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q;
    logic [15:0] flush_count_q;
    logic        flush_evt;

    // A redirect counts only if it is acted on: not masked by halt and not
    // arriving after fetch has stopped.
    assign flush_evt = redirect && !halt && (state_q != S_HALTED);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (push && (fetch_count_q != '1)) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (flush_evt && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + 16'd1;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit: a directed vector table from
// reset, hand-written sequences for halt / async reset / PC wrap, and a
// randomized phase compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] PCI = 32'h0000_0000;
    localparam int          QD  = 2;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b0;
    logic [31:0] imemload = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        instr_ready = 1'b0;
    logic        iREN;
    logic [31:0] imemaddr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_npc;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [15:0] flush_count;
`endif

    instr_fetch_unit #(
        .PC_INIT (PCI),
        .QDEPTH  (QD)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .imemload    (imemload),
        .iREN        (iREN),
        .imemaddr    (imemaddr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_npc   (instr_npc),
        .halted      (halted)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count (fetch_count),
        .flush_count (flush_count)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ih, input logic [31:0] ld, input logic rd,
                         input logic [31:0] rpc, input logic hl, input logic rdy);
        ihit        = ih;
        imemload    = ld;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = hl;
        instr_ready = rdy;
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } qent_t;

    qent_t       mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_faddr;
    bit          m_flushing;
    bit          m_halted;
    bit          m_hpend;
    int unsigned m_fetches;
    int unsigned m_flushes;

    task automatic model_reset();
        mq.delete();
        m_pc       = PCI;
        m_faddr    = PCI;
        m_flushing = 1'b0;
        m_halted   = 1'b0;
        m_hpend    = 1'b0;
        m_fetches  = 0;
        m_flushes  = 0;
    endtask

    function automatic bit m_iren();
        if (m_halted)   return 1'b0;
        if (m_flushing) return 1'b1;
        return (mq.size() < QD);
    endfunction

    task automatic model_check();
        logic [31:0] e_addr;
        e_addr = m_flushing ? m_faddr : m_pc;
        chk("rnd_iREN", {31'd0, iREN}, {31'd0, m_iren()});
        if (!m_halted) chk("rnd_imemaddr", imemaddr, e_addr);
        chk("rnd_halted", {31'd0, halted}, {31'd0, m_halted});
        chk("rnd_valid", {31'd0, instr_valid}, {31'd0, (mq.size() != 0)});
        if (mq.size() != 0) begin
            chk("rnd_instr", instr, mq[0].ins);
            chk("rnd_instr_pc", instr_pc, mq[0].pc);
            chk("rnd_instr_npc", instr_npc, mq[0].pc + 32'd4);
        end else begin
            chk("rnd_instr_empty", instr, 32'd0);
            chk("rnd_pc_empty", instr_pc, 32'd0);
            chk("rnd_npc_empty", instr_npc, 32'd0);
        end
`ifdef FETCH_PERF_EN
        chk("rnd_fetch_count", fetch_count, m_fetches);
        chk("rnd_flush_count", {16'd0, flush_count}, m_flushes);
`endif
    endtask

    task automatic model_step(input bit ih, input logic [31:0] ld, input bit rd,
                              input logic [31:0] rpc, input bit hl, input bit rdy);
        bit iren;
        iren = m_iren();
        if (m_halted) begin
            // nothing leaves the halted condition except reset
        end else if (hl) begin
            mq.delete();
            if (iren && !ih) begin
                m_hpend = 1'b1;
                if (!m_flushing) begin
                    m_faddr    = m_pc;
                    m_flushing = 1'b1;
                end
            end else begin
                m_flushing = 1'b0;
                m_halted   = 1'b1;
            end
        end else if (m_flushing) begin
            if (rd) begin
                m_pc = {rpc[31:2], 2'b00};
                m_flushes++;
            end
            if (ih) begin
                m_flushing = 1'b0;
                if (m_hpend) m_halted = 1'b1;
            end
        end else if (rd) begin
            m_flushes++;
            mq.delete();
            if (iren && !ih) begin
                m_faddr    = m_pc;
                m_flushing = 1'b1;
            end
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (iren && ih) begin
                mq.push_back('{ins: ld, pc: m_pc});
                m_pc = m_pc + 32'd4;
                m_fetches++;
            end
        end
    endtask

    task automatic apply_reset();
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        nRST = 1'b0;
        @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        ih;
        logic [31:0] ld;
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_iren;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl[13];

    initial begin
        bit          r_ih, r_rd, r_hl, r_rdy;
        logic [31:0] r_ld, r_rpc;
        int          halted_cycles;

        tbl[0]  = '{1'b1, 32'h13, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   1'b0, 32'h0,   32'h0};
        tbl[1]  = '{1'b1, 32'h13, 1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   1'b1, 32'h0,   32'h13};
        tbl[2]  = '{1'b1, 32'h13, 1'b0, 32'h0,   1'b0, 1'b0, 32'h8,   1'b1, 32'h0,   32'h13};
        tbl[3]  = '{1'b0, 32'h13, 1'b0, 32'h0,   1'b1, 1'b0, 32'h8,   1'b1, 32'h0,   32'h13};
        tbl[4]  = '{1'b1, 32'h13, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'h4,   32'h13};
        tbl[5]  = '{1'b1, 32'h13, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b1, 32'h8,   32'h13};
        tbl[6]  = '{1'b0, 32'h13, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, 32'hC,   32'h13};
        tbl[7]  = '{1'b0, 32'h13, 1'b1, 32'h200, 1'b1, 1'b1, 32'h10,  1'b0, 32'h0,   32'h0};
        tbl[8]  = '{1'b0, 32'h13, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b0, 32'h0,   32'h0};
        tbl[9]  = '{1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0};
        tbl[10] = '{1'b1, 32'h13, 1'b0, 32'h0,   1'b0, 1'b1, 32'h200, 1'b0, 32'h0,   32'h0};
        tbl[11] = '{1'b1, 32'h13, 1'b1, 32'h103, 1'b0, 1'b1, 32'h204, 1'b1, 32'h200, 32'h13};
        tbl[12] = '{1'b0, 32'h13, 1'b0, 32'h0,   1'b0, 1'b1, 32'h100, 1'b0, 32'h0,   32'h0};

        // Reset state while nRST is held low.
        #2;
        chk("rst_iREN", {31'd0, iREN}, 32'd0);
        chk("rst_imemaddr", imemaddr, PCI);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_instr_npc", instr_npc, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        @(posedge CLK);
        #1 nRST = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].ih, tbl[i].ld, tbl[i].rd, tbl[i].rpc, 1'b0, tbl[i].rdy);
            @(negedge CLK);
            chk($sformatf("tbl%0d_iREN", i), {31'd0, iREN}, {31'd0, tbl[i].e_iren});
            chk($sformatf("tbl%0d_addr", i), imemaddr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d_instr", i), instr, tbl[i].e_instr);
            chk($sformatf("tbl%0d_npc", i), instr_npc,
                tbl[i].e_valid ? tbl[i].e_pc + 32'd4 : 32'd0);
            @(posedge CLK);
            #1;
        end

        // Halt while a miss to 0x100 is outstanding.
        drive(1'b0, 32'h13, 1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge CLK);
        chk("h1_addr", imemaddr, 32'h100);
        @(posedge CLK); #1;
        drive(1'b0, 32'h13, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("h2_iREN", {31'd0, iREN}, 32'd1);
        chk("h2_addr_held", imemaddr, 32'h100);
        chk("h2_halted", {31'd0, halted}, 32'd0);
        @(posedge CLK); #1;
        drive(1'b1, 32'h13, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("h3_addr_held", imemaddr, 32'h100);
        @(posedge CLK); #1;
        drive(1'b0, 32'h13, 1'b1, 32'h400, 1'b0, 1'b1);
        @(negedge CLK);
        chk("h4_halted", {31'd0, halted}, 32'd1);
        chk("h4_iREN", {31'd0, iREN}, 32'd0);
        chk("h4_valid", {31'd0, instr_valid}, 32'd0);
        @(posedge CLK); #1;
        drive(1'b1, 32'h13, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge CLK);
        chk("h5_halted", {31'd0, halted}, 32'd1);
        chk("h5_iREN", {31'd0, iREN}, 32'd0);
        @(posedge CLK); #1;

        // Asynchronous reset clears halted and drops iREN immediately.
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        nRST = 1'b0;
        #1;
        chk("ar_iREN", {31'd0, iREN}, 32'd0);
        chk("ar_halted", {31'd0, halted}, 32'd0);
        chk("ar_addr", imemaddr, PCI);
        @(posedge CLK);
        #1 nRST = 1'b1;
        @(negedge CLK);
        chk("ar_resume_iREN", {31'd0, iREN}, 32'd1);
        chk("ar_resume_addr", imemaddr, PCI);
        @(posedge CLK); #1;

        // PC wrap: redirect (with hit, word dropped) to the last word.
        drive(1'b1, 32'h13, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        @(posedge CLK); #1;
        drive(1'b1, 32'h13, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("w_addr_top", imemaddr, 32'hFFFF_FFFC);
        chk("w_valid0", {31'd0, instr_valid}, 32'd0);
        @(posedge CLK); #1;
        drive(1'b0, 32'h13, 1'b1, 32'h40, 1'b0, 1'b0);
        @(negedge CLK);
        chk("w_addr_wrap", imemaddr, 32'h0);
        chk("w_instr_pc", instr_pc, 32'hFFFF_FFFC);
        chk("w_instr_npc", instr_npc, 32'h0);
        @(posedge CLK); #1;
        drive(1'b0, 32'h13, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("w_flush_addr", imemaddr, 32'h0);
        chk("w_flush_valid", {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_PERF_EN
        chk("w_fetch_count", fetch_count, 32'd1);
        chk("w_flush_count", {16'd0, flush_count}, 32'd2);
`endif
        @(posedge CLK); #1;

        // Randomized phase against the reference model.
        apply_reset();
        model_reset();
        halted_cycles = 0;
        for (int n = 0; n < 4000; n++) begin
            if (m_halted) begin
                halted_cycles++;
                if (halted_cycles > 3 && $urandom_range(0, 3) == 0) begin
                    apply_reset();
                    model_reset();
                    halted_cycles = 0;
                end
            end
            r_ih  = ($urandom_range(0, 1) == 1);
            r_ld  = $urandom;
            r_rd  = ($urandom_range(0, 9) == 0);
            r_rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                 : ($urandom & 32'h0000_0FFF);
            r_hl  = ($urandom_range(0, 199) == 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            drive(r_ih, r_ld, r_rd, r_rpc, r_hl, r_rdy);
            @(negedge CLK);
            model_check();
            @(posedge CLK);
            model_step(r_ih, r_ld, r_rd, r_rpc, r_hl, r_rdy);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Supplies the decode stage's instruction word: the producer feeding the control unit's `instr` input. Consumes the control unit's `halt` and the execute stage's resolved redirect.
- Sits between the per-core instruction cache port (`iREN`/`ihit`/`imemaddr`/`imemload`) and decode.
- Holds a PC register and a small instruction queue. Provides a valid/ready handshake toward decode and a flush-on-redirect protocol that never changes the cache address while a request is outstanding.

Parameters:
PC_INIT, 32'h0000_0000, PC loaded at reset
QDEPTH, 2, instruction queue entries; power of two, >= 2

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
ihit  input  1  cache returns word for imemaddr this cycle
imemload  input  32  instruction word, valid when ihit
iREN  output  1  instruction read request
imemaddr  output  32  request address, word aligned
redirect  input  1  taken branch/jump resolved; flush and refetch
redirect_pc  input  32  new fetch PC, valid with redirect
halt  input  1  decoded halt consumed by decode; stop fetching
instr_ready  input  1  decode accepts head of queue
instr_valid  output  1  queue head valid
instr  output  32  queue head instruction word
instr_pc  output  32  PC of queue head
instr_npc  output  32  instr_pc + 4
halted  output  1  fetch permanently stopped

Behaviour:
- Interface: one clock `CLK`; reset `nRST` is asynchronous and active-low.
- Reset values: pc=PC_INIT, queue empty, state=RUN, halt_pending=0. All outputs 0 except imemaddr=PC_INIT.
- States:
  - RUN: iREN=!full, imemaddr=pc.
  - FLUSH: iREN=1, imemaddr=flush_addr; the word returned by ihit is discarded.
  - HALTED: iREN=0, halted=1.
- Address stability: while iREN=1 and ihit=0, imemaddr is held constant.
- RUN, ihit, no redirect, no halt: push {imemload, pc}; pc<=pc+4 (mod 2^32, wraps from FFFF_FFFC to 0).
- RUN, redirect:
  - Queue cleared; pc<=redirect_pc; instr_valid=0 next cycle.
  - If iREN=1 and ihit=0: flush_addr<=pc, go to FLUSH.
  - If ihit=1 the same cycle: the word is dropped and the unit stays in RUN.
  - If iREN=0 (queue full): stays in RUN.
- FLUSH, ihit: discard the word. Go to HALTED if halt_pending, else RUN, and the next request uses pc.
- FLUSH, redirect: pc<=redirect_pc; stay in FLUSH (flush_addr unchanged).
- halt (any state other than HALTED): queue cleared.
  - If a request is outstanding without ihit: set halt_pending and go to FLUSH.
  - Otherwise go to HALTED.
- Priority: halt beats redirect.
- HALTED is left only by reset.
- Queue: circular buffer with read/write pointers and count (width clog2(QDEPTH)+1).
  - Pop when instr_valid && instr_ready.
  - Simultaneous push and pop is allowed (count unchanged).
  - Push only when not full; pop only when not empty.
  - Flush overrides push and pop in the same cycle.
- instr/instr_pc/instr_npc are driven combinationally from the queue head; they are 0 when empty.
- Latency: first instruction is visible one cycle after the first ihit.
- Reset asserted mid-request: all state is cleared immediately and iREN drops asynchronously.
- redirect_pc[1:0] is ignored (forced to 0).

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs fetch_count (32) and flush_count (16).
  - fetch_count increments on every queue push.
  - flush_count increments on every redirect accepted outside HALTED.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, ihit every cycle, instr_ready=1, imemload=0x00000013 -> imemaddr 0,4,8,...; instr_pc tracks with one-cycle lag; instr_npc=instr_pc+4.
- instr_ready=0, ihit every cycle, QDEPTH=2 -> after 2 pushes iREN=0, imemaddr=0x8, queue holds PCs 0x0 and 0x4; raise instr_ready -> pops in order and iREN reasserts.
- Request to 0x10 pending with ihit=0, redirect with redirect_pc=0x200 -> state FLUSH, imemaddr stays 0x10 until ihit, that word is dropped; next request is 0x200 and instr_valid=0 in between.
- redirect and ihit in the same cycle, redirect_pc=0x103 -> returned word dropped; next imemaddr=0x100.
- halt while request pending -> FLUSH until ihit, then halted=1 and iREN=0 permanently; subsequent redirect is ignored; nRST low clears and resumes at PC_INIT.
- pc=0xFFFF_FFFC with ihit -> next imemaddr=0x0; with FETCH_PERF_EN, fetch_count equals the number of pushes and flush_count=2 after two redirects.
